apb_completer: RTL and testbench

//  APB4 completer: the responder end of our APB master. Owns a DEPTH-word register file
//  and answers SETUP/ACCESS transfers with programmable wait states, byte strobes and

---
 rtl/apb_pkg.sv | 20 ++
 rtl/apb_regfile.sv | 36 +++
 rtl/apb_completer.sv | 114 +++++++++++
 tb/tb_apb_completer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and widths for the APB4 completer and its register file.
package apb_pkg;
  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = 4;
  localparam int APB_WCNT_W = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_t;

  // Transfer fields captured at the setup edge and held through ACCESS.
  typedef struct packed {
    logic                  write;
    logic [APB_STRB_W-1:0] strb;
    logic [APB_DATA_W-1:0] wdata;
    logic                  err;
  } apb_req_t;
endpackage

// File: rtl/apb_regfile.sv
// DEPTH x 32 register file: byte-strobed write port, registered read port, async clear.
module apb_regfile
  import apb_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  we,
  input  logic [IDX_W-1:0]      widx,
  input  logic [APB_STRB_W-1:0] wstrb,
  input  logic [APB_DATA_W-1:0] wdata,
  input  logic                  re,
  input  logic [IDX_W-1:0]      ridx,
  input  logic                  rzero,
  output logic [APB_DATA_W-1:0] rdata
);
  // Storage is split per byte lane so each strobe owns its own state.
  for (genvar b = 0; b < APB_STRB_W; b++) begin : g_lane
    logic [DEPTH-1:0][7:0] lane_mem;
    logic [7:0]            lane_rd;

    always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
        lane_mem <= '0;
        lane_rd  <= '0;
      end else begin
        if (we && wstrb[b]) lane_mem[widx] <= wdata[8*b +: 8];
        if (re)             lane_rd        <= rzero ? 8'h00 : lane_mem[ridx];
      end
    end

    assign rdata[8*b +: 8] = lane_rd;
  end
endmodule

// File: rtl/apb_completer.sv
// APB4 completer with wait states, byte strobes and PSLVERR.
// Define APB_PPROT_CHECK_EN to reject unprivileged access at or above PROT_BASE.
module apb_completer
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = APB_ADDR_W,
  parameter int DATA_WIDTH  = APB_DATA_W,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 1,
  parameter int PROT_BASE   = 8
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [APB_STRB_W-1:0] PSTRB,
  input  logic [2:0]            PPROT,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);
  localparam int IDX_W = $clog2(DEPTH);

  apb_state_t            state, state_nxt;
  logic [APB_WCNT_W-1:0] wcnt;
  apb_req_t              req;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W-1:0]      idx_d;
  logic                  setup, complete, err_d;
  logic [ADDR_WIDTH-1:0] widx_full;

  assign idx_d     = PADDR[2 +: IDX_W];
  assign widx_full = PADDR >> 2;
  assign setup     = (state == IDLE) && PSEL && !PENABLE;
  assign complete  = (state == ACCESS) && PSEL && PENABLE && (wcnt == '0);

  always_comb begin
    err_d = (PADDR[1:0] != 2'b00) ||
            (widx_full >= ADDR_WIDTH'(DEPTH)) ||
            (!PWRITE && (PSTRB != '0));
`ifdef APB_PPROT_CHECK_EN
    if ((widx_full >= ADDR_WIDTH'(PROT_BASE)) && !PPROT[0]) err_d = 1'b1;
`else
    begin : g_no_prot
    end
`endif
  end

`ifndef APB_PPROT_CHECK_EN
  logic unused_prot;
  assign unused_prot = ^PPROT;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Completion always returns to IDLE; a back-to-back setup is taken next cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (setup) state_nxt = ACCESS;
      ACCESS:  if (!PSEL || complete) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wcnt  <= '0;
      req   <= '0;
      idx_q <= '0;
    end else if (setup) begin
      wcnt      <= APB_WCNT_W'(WAIT_STATES);
      req.write <= PWRITE;
      req.strb  <= PSTRB;
      req.wdata <= APB_DATA_W'(PWDATA);
      req.err   <= err_d;
      idx_q     <= idx_d;
    end else if ((state == ACCESS) && PSEL && (wcnt != '0)) begin
      wcnt <= wcnt - APB_WCNT_W'(1);
    end
  end

  // Outputs come only from registered state so there is no PSEL/PENABLE->PREADY path.
  always_comb begin
    PREADY  = (state == ACCESS) && (wcnt == '0);
    PSLVERR = PREADY && req.err;
  end

  logic [APB_DATA_W-1:0] rdata;

  apb_regfile #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_regfile (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .we      (complete && req.write && !req.err),
    .widx    (idx_q),
    .wstrb   (req.strb),
    .wdata   (req.wdata),
    .re      (setup),
    .ridx    (idx_d),
    .rzero   (err_d),
    .rdata   (rdata)
  );

  assign PRDATA = DATA_WIDTH'(rdata);
endmodule

// File: tb/tb_apb_completer.sv
// Directed bench for apb_completer (DEPTH=16, WAIT_STATES=1).
module tb_apb_completer;
  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;

  int checks = 0;
  int errors = 0;

  apb_completer #(
    .ADDR_WIDTH (32), .DATA_WIDTH (32), .DEPTH (16), .WAIT_STATES (1), .PROT_BASE (8)
  ) dut (
    .PCLK (PCLK), .PRESETn (PRESETn), .PSEL (PSEL), .PENABLE (PENABLE),
    .PWRITE (PWRITE), .PADDR (PADDR), .PWDATA (PWDATA), .PSTRB (PSTRB),
    .PPROT (PPROT), .PRDATA (PRDATA), .PREADY (PREADY), .PSLVERR (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one transfer starting just after a rising edge; returns just after the completion edge.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] p,
                      output logic [31:0] rd, output logic err, output int lat,
                      output logic done);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d; PSTRB = s; PPROT = p;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    lat = 0; done = 1'b0; rd = 'x; err = 1'bx;
    for (int i = 0; i < 32 && !done; i++) begin
      @(negedge PCLK);
      lat++;
      if (PREADY) begin
        done = 1'b1; rd = PRDATA; err = PSLVERR;
      end
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  logic [31:0] rd;
  logic        err, done;
  int          lat;

  initial begin
    PRESETn = 1'b0; PSEL = 0; PENABLE = 0; PWRITE = 0;
    PADDR = 0; PWDATA = 0; PSTRB = 0; PPROT = 0;
    repeat (2) @(negedge PCLK);
    chk("rst_pready", 32'(PREADY), 32'd0);
    chk("rst_pslverr", 32'(PSLVERR), 32'd0);
    chk("rst_prdata", PRDATA, 32'd0);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;

    xfer(1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 3'b001, rd, err, lat, done);
    chk("wr4_done", 32'(done), 32'd1);
    chk("wr4_lat", 32'(lat), 32'd2);
    chk("wr4_err", 32'(err), 32'd0);
    @(negedge PCLK);
    chk("wr4_pready_drop", 32'(PREADY), 32'd0);
    @(posedge PCLK); #1;

    xfer(1'b0, 32'h04, 32'h0, 4'h0, 3'b001, rd, err, lat, done);
    chk("rd4_data", rd, 32'hDEADBEEF);
    chk("rd4_err", 32'(err), 32'd0);
    chk("rd4_lat", 32'(lat), 32'd2);

    xfer(1'b1, 32'h04, 32'h0000AA00, 4'b0010, 3'b001, rd, err, lat, done);
    chk("wrstrb_err", 32'(err), 32'd0);
    xfer(1'b0, 32'h04, 32'h0, 4'h0, 3'b001, rd, err, lat, done);
    chk("rdstrb_data", rd, 32'hDEADAAEF);

    xfer(1'b1, 32'h04, 32'hFFFFFFFF, 4'h0, 3'b001, rd, err, lat, done);
    chk("wrnostrb_err", 32'(err), 32'd0);
    xfer(1'b0, 32'h04, 32'h0, 4'h0, 3'b001, rd, err, lat, done);
    chk("wrnostrb_data", rd, 32'hDEADAAEF);

    xfer(1'b0, 32'h02, 32'h0, 4'h0, 3'b001, rd, err, lat, done);
    chk("misalign_err", 32'(err), 32'd1);
    chk("misalign_data", rd, 32'd0);
    @(negedge PCLK);
    chk("misalign_slverr_drop", 32'(PSLVERR), 32'd0);
    @(posedge PCLK); #1;
    xfer(1'b0, 32'h40, 32'h0, 4'h0, 3'b001, rd, err, lat, done);
    chk("oor_rd_err", 32'(err), 32'd1);
    chk("oor_rd_data", rd, 32'd0);
    xfer(1'b0, 32'h04, 32'h0, 4'h1, 3'b001, rd, err, lat, done);
    chk("rdstrb_nz_err", 32'(err), 32'd1);
    chk("rdstrb_nz_data", rd, 32'd0);
    xfer(1'b1, 32'h40, 32'h12345678, 4'hF, 3'b001, rd, err, lat, done);
    chk("oor_wr_err", 32'(err), 32'd1);
    xfer(1'b0, 32'h00, 32'h0, 4'h0, 3'b001, rd, err, lat, done);
    chk("oor_wr_noalias", rd, 32'd0);

    // Back-to-back: second setup is driven in the cycle right after completion.
    xfer(1'b1, 32'h00, 32'hCAFEF00D, 4'hF, 3'b001, rd, err, lat, done);
    chk("b2b_wr_lat", 32'(lat), 32'd2);
    xfer(1'b0, 32'h00, 32'h0, 4'h0, 3'b001, rd, err, lat, done);
    chk("b2b_rd_lat", 32'(lat), 32'd2);
    chk("b2b_rd_data", rd, 32'hCAFEF00D);

`ifdef APB_PPROT_CHECK_EN
    xfer(1'b1, 32'h20, 32'h55AA55AA, 4'hF, 3'b000, rd, err, lat, done);
    chk("prot_wr_err", 32'(err), 32'd1);
    xfer(1'b0, 32'h20, 32'h0, 4'h0, 3'b001, rd, err, lat, done);
    chk("prot_blocked", rd, 32'd0);
    xfer(1'b1, 32'h20, 32'h55AA55AA, 4'hF, 3'b001, rd, err, lat, done);
    chk("prot_ok_err", 32'(err), 32'd0);
    xfer(1'b0, 32'h20, 32'h0, 4'h0, 3'b000, rd, err, lat, done);
    chk("prot_rd_unpriv_err", 32'(err), 32'd1);
    xfer(1'b0, 32'h20, 32'h0, 4'h0, 3'b001, rd, err, lat, done);
    chk("prot_ok_data", rd, 32'h55AA55AA);
`else
    xfer(1'b1, 32'h20, 32'h55AA55AA, 4'hF, 3'b000, rd, err, lat, done);
    chk("noprot_wr_err", 32'(err), 32'd0);
    xfer(1'b0, 32'h20, 32'h0, 4'h0, 3'b000, rd, err, lat, done);
    chk("noprot_data", rd, 32'h55AA55AA);
`endif

    // Reset lands in the middle of the ACCESS phase of a write to 0x08.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h08;
    PWDATA = 32'hA5A5A5A5; PSTRB = 4'hF; PPROT = 3'b001;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    PRESETn = 1'b0;
    #1;
    chk("rst_mid_pready", 32'(PREADY), 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    xfer(1'b0, 32'h08, 32'h0, 4'h0, 3'b001, rd, err, lat, done);
    chk("rst_mid_reg2", rd, 32'd0);
    xfer(1'b0, 32'h04, 32'h0, 4'h0, 3'b001, rd, err, lat, done);
    chk("rst_mid_reg1", rd, 32'd0);
    chk("final_done", 32'(done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
